alu_cmd_issuer: RTL and testbench



---
 rtl/alu_cmd_issuer_if.sv | 25 ++
 rtl/alu_cmd_issuer.sv | 84 ++++++++
 tb/tb_alu_cmd_issuer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: command, ALU and result channels of the ALU command issuer
interface alu_cmd_issuer_if;
   logic       cmd_valid, cmd_ready, cmd_cin;
   logic [7:0] cmd_a, cmd_b;
   logic [3:0] cmd_s;
   logic [7:0] A, B, F;
   logic       cin;
   logic [3:0] s;
   logic       OVERFLOW, CARRY, ZERO, A_GREATER_B, A_SMALLER_B, A_EQUAL_B;
   logic       res_valid, res_ready;
   logic [7:0] res_F;
   logic [5:0] res_flags;
   logic [3:0] res_s;
   logic       busy;
   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_s, F,
             OVERFLOW, CARRY, ZERO, A_GREATER_B, A_SMALLER_B, A_EQUAL_B, res_ready,
      output cmd_ready, A, B, cin, s, res_valid, res_F, res_flags, res_s, busy
   );
   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_s, F,
             OVERFLOW, CARRY, ZERO, A_GREATER_B, A_SMALLER_B, A_EQUAL_B, res_ready,
      input  cmd_ready, A, B, cin, s, res_valid, res_F, res_flags, res_s, busy
   );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands, holds operands for the ALU latency, registers the result
module alu_cmd_issuer #(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input logic              clk,
   input logic              rst,
   alu_cmd_issuer_if.slave  io
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(ALU_LAT + 2);
   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
   state_t          state_q, state_d;
   logic [20:0]     mem [DEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [AW:0]     cnt_q;
   logic [CW-1:0]   wait_q, wait_d;
   logic [20:0]     op_q, op_d;
   logic [17:0]     res_q, res_d;
   logic            res_valid_q, res_valid_d;
   logic            push, pop, capture, empty;
   assign empty        = cnt_q == '0;
   assign io.cmd_ready = cnt_q != (AW+1)'(DEPTH);
   assign push         = io.cmd_valid && io.cmd_ready;
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      pop         = 1'b0;
      capture     = 1'b0;
      case (state_q)
         IDLE: begin
            pop     = !empty;
            state_d = empty ? IDLE : WAIT;
         end
         WAIT: begin
            capture = wait_q == '0;
            state_d = capture ? HOLD : WAIT;
            wait_d  = capture ? wait_q : wait_q - CW'(1);
         end
         HOLD: begin
            pop     = io.res_ready && !empty;
            state_d = !io.res_ready ? HOLD : empty ? IDLE : WAIT;
         end
         default: state_d = IDLE;
      endcase
      wait_d      = pop ? CW'(ALU_LAT) : wait_d;
      op_d        = pop ? mem[rd_q] : op_q;
      // res_s comes from the held opcode, which is what the ALU is evaluating
      res_d       = capture ? {io.F, io.OVERFLOW, io.CARRY, io.ZERO, io.A_GREATER_B,
                               io.A_SMALLER_B, io.A_EQUAL_B, op_q[3:0]} : res_q;
      res_valid_d = capture ? 1'b1 : (state_q == HOLD && io.res_ready) ? 1'b0 : res_valid_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         wait_q      <= '0;
         op_q        <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_q + AW'(push);
         rd_q        <= rd_q + AW'(pop);
         cnt_q       <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
         wait_q      <= wait_d;
         op_q        <= op_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
      end
   end
   always_ff @(posedge clk) if (push) mem[wr_q] <= {io.cmd_a, io.cmd_b, io.cmd_cin, io.cmd_s};
   assign io.A         = op_q[20:13];
   assign io.B         = op_q[12:5];
   assign io.cin       = op_q[4];
   assign io.s         = op_q[3:0];
   assign io.res_F     = res_q[17:10];
   assign io.res_flags = res_q[9:4];
   assign io.res_s     = res_q[3:0];
   assign io.res_valid = res_valid_q;
   assign io.busy      = !empty || state_q != IDLE;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: randomized scoreboard bench for a registered-ALU and a combinational-ALU build
module tb_alu_cmd_issuer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0, n_bad = 0;
   logic rdy1 = 1'b0, rdy0 = 1'b0, rnd1 = 1'b0;
   logic [17:0] exp1[$], exp0[$];
   int   hs1[$];
   logic [18:0] prev1, prev0;
   logic hold1 = 1'b0, hold0 = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   alu_cmd_issuer_if b1();
   alu_cmd_issuer_if b0();
   alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(1)) u1 (.clk(clk), .rst(rst), .io(b1.slave));
   alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(0)) u0 (.clk(clk), .rst(rst), .io(b0.slave));
   // behavioural ALU_8: {F, OVERFLOW, CARRY, ZERO, A>B, A<B, A==B}
   function automatic logic [13:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic [3:0] op);
      logic [8:0] r;
      logic ov;
      ov = 1'b0;
      case (op)
         4'd0: begin r = a + b + c; ov = (a[7] == b[7]) && (r[7] != a[7]); end
         4'd1: begin r = {1'b0, a} - {1'b0, b} - c; ov = (a[7] != b[7]) && (r[7] != a[7]); end
         4'd3: r = 9'd256 - {1'b0, a};
         4'd8: r = {1'b0, a & b};
         4'd9: r = {1'b0, a ^ b};
         4'd10: r = {1'b0, a | b};
         4'd11: r = {1'b0, ~a};
         4'd12: r = {a[0], a[0], a[7:1]};
         4'd13: r = {a[7], a[6:0], a[7]};
         4'd14: r = {a[0], 1'b0, a[7:1]};
         4'd15: r = {a, 1'b0};
         default: r = {1'b0, a};
      endcase
      return {r[7:0], ov, r[8], r[7:0] == 8'd0, a > b, a < b, a == b};
   endfunction
   always_ff @(posedge clk)
      {b1.F, b1.OVERFLOW, b1.CARRY, b1.ZERO, b1.A_GREATER_B, b1.A_SMALLER_B, b1.A_EQUAL_B}
         <= alu(b1.A, b1.B, b1.cin, b1.s);
   always_comb
      {b0.F, b0.OVERFLOW, b0.CARRY, b0.ZERO, b0.A_GREATER_B, b0.A_SMALLER_B, b0.A_EQUAL_B}
         = alu(b0.A, b0.B, b0.cin, b0.s);
   always @(posedge clk) begin
      #2;
      b1.res_ready = rnd1 ? ($urandom_range(0, 3) != 0) : rdy1;
      b0.res_ready = rdy0;
   end
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   // scoreboards: compare on every completed result handshake, and check held results stay put
   always @(negedge clk) begin
      if (!rst) begin
         if (hold1) check("hold1", {b1.res_valid, b1.res_F, b1.res_flags, b1.res_s}, prev1);
         if (b1.res_valid && b1.res_ready) begin
            if (exp1.size() == 0) check("unexpected1", b1.res_valid, 0);
            else check("res1", {b1.res_F, b1.res_flags, b1.res_s}, exp1.pop_front());
            hs1.push_back(cyc);
         end
         hold1 <= b1.res_valid && !b1.res_ready;
         prev1 <= {b1.res_valid, b1.res_F, b1.res_flags, b1.res_s};
      end else hold1 <= 1'b0;
   end
   always @(negedge clk) begin
      if (!rst) begin
         if (hold0) check("hold0", {b0.res_valid, b0.res_F, b0.res_flags, b0.res_s}, prev0);
         if (b0.res_valid && b0.res_ready) begin
            if (exp0.size() == 0) check("unexpected0", b0.res_valid, 0);
            else check("res0", {b0.res_F, b0.res_flags, b0.res_s}, exp0.pop_front());
         end
         hold0 <= b0.res_valid && !b0.res_ready;
         prev0 <= {b0.res_valid, b0.res_F, b0.res_flags, b0.res_s};
      end else hold0 <= 1'b0;
   end
   task automatic push(input int u, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [3:0] s);
      int  t;
      logic acc;
      @(posedge clk); #2;
      if (u == 1) begin b1.cmd_valid = 1; b1.cmd_a = a; b1.cmd_b = b; b1.cmd_cin = c; b1.cmd_s = s; end
      else begin b0.cmd_valid = 1; b0.cmd_a = a; b0.cmd_b = b; b0.cmd_cin = c; b0.cmd_s = s; end
      t = 0;
      acc = 1'b0;
      while (!acc) begin
         @(negedge clk);
         acc = (u == 1) ? b1.cmd_ready : b0.cmd_ready;
         t++;
         if (!acc && t > 300) begin
            n_bad++;
            $display("FAIL push_timeout: cmd_ready stuck low, expected high within 300 cycles");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $fatal(1);
         end
         if (!acc) begin @(posedge clk); #2; end
      end
      if (u == 1) exp1.push_back({alu(a, b, c, s), s});
      else exp0.push_back({alu(a, b, c, s), s});
   endtask
   task automatic release_cmd(input int u);
      @(posedge clk); #2;
      if (u == 1) b1.cmd_valid = 0; else b0.cmd_valid = 0;
   endtask
   task automatic drain(input int u, input string nm);
      int t;
      t = 0;
      while (((u == 1) ? (exp1.size() != 0 || b1.busy) : (exp0.size() != 0 || b0.busy)) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check(nm, t < 2000, 1);
   endtask
   initial begin
      b1.cmd_valid = 0; b1.cmd_a = 0; b1.cmd_b = 0; b1.cmd_cin = 0; b1.cmd_s = 0; b1.res_ready = 0;
      b0.cmd_valid = 0; b0.cmd_a = 0; b0.cmd_b = 0; b0.cmd_cin = 0; b0.cmd_s = 0; b0.res_ready = 0;
      repeat (2) @(posedge clk);
      #2 rst = 0;
      @(negedge clk);
      check("rst_res_valid", b1.res_valid, 0);
      check("rst_ab", {b1.A, b1.B, b1.cin, b1.s}, 0);
      check("rst_busy", b1.busy, 0);
      check("rst_cmd_ready", b1.cmd_ready, 1);
      // ADD FF+FF: result must appear exactly after edge N+3 with operands held
      push(1, 8'hFF, 8'hFF, 1'b0, 4'd0);
      release_cmd(1);
      @(negedge clk);
      @(negedge clk);
      check("add_wait1_valid", b1.res_valid, 0);
      check("add_wait1_ab", {b1.A, b1.B}, 16'hFFFF);
      @(negedge clk);
      check("add_wait2_valid", b1.res_valid, 0);
      check("add_wait2_ab", {b1.A, b1.B}, 16'hFFFF);
      @(negedge clk);
      check("add_valid", b1.res_valid, 1);
      check("add_F", b1.res_F, 8'hFE);
      check("add_carry", b1.res_flags[4], 1);
      rdy1 = 1;
      drain(1, "drain_add");
      // back-to-back with res_ready high: results spaced ALU_LAT+2 cycles
      hs1.delete();
      push(1, 8'h02, 8'h03, 1'b0, 4'd1);
      push(1, 8'h02, 8'h03, 1'b0, 4'd8);
      push(1, 8'h02, 8'h00, 1'b0, 4'd13);
      release_cmd(1);
      drain(1, "drain_b2b");
      check("b2b_count", hs1.size(), 3);
      if (hs1.size() == 3) begin
         check("b2b_gap1", hs1[1] - hs1[0], 3);
         check("b2b_gap2", hs1[2] - hs1[1], 3);
      end
      // backpressure: five commands with res_ready low fill the FIFO behind the held result
      rdy1 = 0;
      for (int i = 0; i < 5; i++) push(1, 8'(8'h10 + i), 8'(8'h20 + 3 * i), 1'b0, 4'(i % 2));
      release_cmd(1);
      @(negedge clk);
      check("full_cmd_ready", b1.cmd_ready, 0);
      check("full_res_valid", b1.res_valid, 1);
      check("full_held_F", b1.res_F, 8'h30);
      // a push offered on the same edge the FIFO is popped is refused, then taken next cycle
      rdy1 = 1;
      @(posedge clk); #2;
      b1.cmd_valid = 1; b1.cmd_a = 8'h5A; b1.cmd_b = 8'h0F; b1.cmd_cin = 0; b1.cmd_s = 4'd9;
      @(negedge clk);
      check("pop_push_ready", b1.cmd_ready, 0);
      @(negedge clk);
      check("after_pop_ready", b1.cmd_ready, 1);
      exp1.push_back({alu(8'h5A, 8'h0F, 1'b0, 4'd9), 4'd9});
      release_cmd(1);
      drain(1, "drain_full");
      // reset during WAIT discards the operation
      push(1, 8'h12, 8'h34, 1'b1, 4'd0);
      release_cmd(1);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1;
      exp1.delete();
      exp0.delete();
      #1;
      check("mid_rst_valid", b1.res_valid, 0);
      check("mid_rst_ab", {b1.A, b1.B}, 0);
      check("mid_rst_busy", b1.busy, 0);
      @(posedge clk); #2 rst = 0;
      push(1, 8'h40, 8'h41, 1'b1, 4'd0);
      release_cmd(1);
      drain(1, "drain_post_rst");
      // random traffic with random downstream backpressure
      rnd1 = 1;
      for (int i = 0; i < 80; i++) begin
         push(1, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            release_cmd(1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
         end
      end
      release_cmd(1);
      rnd1 = 0;
      drain(1, "drain_rand1");
      // combinational-ALU build: XOR 02^03 valid after edge N+2
      push(0, 8'h02, 8'h03, 1'b0, 4'd9);
      release_cmd(0);
      @(negedge clk);
      @(negedge clk);
      check("lat0_wait_valid", b0.res_valid, 0);
      @(negedge clk);
      check("lat0_valid", b0.res_valid, 1);
      check("lat0_F", b0.res_F, 8'h01);
      rdy0 = 1;
      drain(0, "drain_lat0");
      for (int i = 0; i < 40; i++) push(0, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
      release_cmd(0);
      drain(0, "drain_rand0");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
